bram_pingpong_ctrl: RTL and testbench
=====================================

BRAM_PINGPONG_CTRL -- requirements
Module: bram_pingpong_ctrl

Interface
REQ-001 Parameter BANK_WORDS, default 4096, 32-bit words per BRAM bank; power of two, 2..65536.
REQ-002 Parameter OVF_W, default 16, width of the overflow counter.
REQ-003 clk  in  1  single clock; all logic on rising edge; also driven out as clkb.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 sinc  in  1  active-low pulse-sync from TX; a capture is triggered by its falling edge.
REQ-006 valid  in  1  sample strobe; datos is valid while high.
REQ-007 datos  in  32  ADC sample word.
REQ-008 n_samples  in  32  requested words per capture; latched at capture start.
REQ-009 rdy_w  in  2  PS release pulses; bit i frees bank i.
REQ-010 addr  out  32  BRAM byte address.
REQ-011 clkb  out  1  equal to clk.
REQ-012 din  out  32  equal to datos.
REQ-013 en  out  1  BRAM port enable.
REQ-014 we  out  4  byte write enables.
REQ-015 rdy  out  2  bank-full flags; bit i set means bank i holds data for the PS.
REQ-016 size_data  out  32  word count of the most recently completed capture.
REQ-017 bank  out  1  bank being written in CAPT, or next target otherwise.
REQ-018 busy  out  1  high in CAPT.
REQ-019 ovf_cnt  out  OVF_W  count of dropped triggers, saturating.

Function
REQ-020 The block shall detect the trigger edge as ~sinc & sinc_q, where sinc_q is sinc registered once (reset value 1).
REQ-021 FSM states:
- IDLE: on edge with rdy[bank]=0, go to CAPT next cycle.
- IDLE: on edge with rdy[bank]=1, stay in IDLE and increment ovf_cnt.
- CAPT: on the write that makes cnt equal to N, go to DONE.
- DONE: always go to IDLE after 1 cycle.
REQ-022 On IDLE->CAPT the block shall latch N = n_samples, or N = BANK_WORDS if n_samples is 0 or greater than BANK_WORDS, and shall clear cnt.
REQ-023 In CAPT, each cycle with valid=1 shall produce a write with en=1 and we=4'hF in that same cycle (combinational), then increment cnt.
REQ-024 Outside such cycles en shall be 0 and we shall be 4'h0.
REQ-025 addr shall equal (bank*BANK_WORDS + cnt)*4, zero-extended to 32 bits; writes shall never leave the active bank.
REQ-026 DONE shall, in one cycle, set rdy[bank], load size_data with N, and toggle bank; banks strictly alternate.
REQ-027 A trigger edge while in CAPT or DONE shall be ignored and shall increment ovf_cnt; an active capture is never restarted.
REQ-028 rdy_w[i]=1 shall clear rdy[i] next cycle.
REQ-029 If DONE sets rdy[i] in the same cycle that rdy_w[i] is high, the set shall win.
REQ-030 rdy_w on a bank whose rdy is 0 shall have no effect.
REQ-031 ovf_cnt shall hold at all-ones once saturated.
REQ-032 Trigger-to-first-write latency shall be 1 cycle: edge in cycle k means a write is possible in cycle k+1 if valid=1.
REQ-033 n_samples changes during CAPT shall not affect the active capture.

Reset
REQ-034 While rst=1, outputs shall be: state IDLE, cnt 0, bank 0, rdy 2'b00, size_data 0, ovf_cnt 0, busy 0, en 0, we 0, addr 0.
REQ-035 rst asserted mid-capture shall abort it with no rdy set; the partial bank contents are undefined.
REQ-036 After rst deasserts, the first trigger shall accept only a sinc falling edge occurring after release.

Verification
REQ-037 Scenario 1: n_samples=8, valid held high, one sinc low pulse -> 8 writes at addr 0x0..0x1C in cycles k+1..k+8; rdy=2'b01 and size_data=8 one cycle after the last write; bank=1.
REQ-038 Scenario 2: valid toggling 1,0 with n_samples=4 -> exactly 4 writes over 8 cycles; addr increments only on written cycles.
REQ-039 Scenario 3: two captures with no rdy_w, then a third trigger -> rdy=2'b11; third trigger dropped with ovf_cnt=1 and no writes; after rdy_w=2'b01 the next trigger writes bank 0 at base 0x0.
REQ-040 Scenario 4: second sinc edge during an active capture -> capture completes with N words; ovf_cnt increments by 1.
REQ-041 Scenario 5: n_samples=0 and n_samples=BANK_WORDS+5 -> each writes BANK_WORDS words; the last bank-1 address is (2*BANK_WORDS-1)*4.
REQ-042 Scenario 6: rst pulsed after 3 of 8 writes -> all outputs at reset values, rdy=0; a following trigger captures into bank 0 from addr 0.

Source files
------------

// File: rtl/bram_pingpong_ctrl.sv
// bram_pingpong_ctrl
//   Captures bursts of ADC samples into one of two BRAM banks (ping-pong).
//   A falling edge on sinc starts a capture into the current bank. Each
//   valid sample is written straight through to the BRAM port. After
//   N words the bank is flagged full for the PS, and the next capture
//   targets the other bank. The PS hands a bank back by pulsing rdy_w[i].
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   sinc             active-low pulse-sync; falling edge triggers a capture
//   valid, datos     sample strobe and 32-bit sample word
//   n_samples        requested words per capture (0 or >BANK_WORDS => full bank)
//   rdy_w[1:0]       PS release pulses, bit i frees bank i
//   addr, clkb, din, en, we   BRAM port (byte address, clock, data, enables)
//   rdy[1:0]         bank-full flags
//   size_data        word count of the most recently completed capture
//   bank             bank being written in CAPT, otherwise next target bank
//   busy             high while capturing
//   ovf_cnt          saturating count of dropped triggers
//   fsm_state        current FSM state (0 IDLE, 1 CAPT, 2 DONE) for debug
//
// Flow control: there is no back-pressure. A sample is consumed in any
// cycle where the FSM is in CAPT and valid=1; samples offered while not
// capturing are discarded. The BRAM port accepts a write in every cycle.
module bram_pingpong_ctrl #(
  parameter int BANK_WORDS = 4096,
  parameter int OVF_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sinc,
  input  logic             valid,
  input  logic [31:0]      datos,
  input  logic [31:0]      n_samples,
  input  logic [1:0]       rdy_w,
  output logic [31:0]      addr,
  output logic             clkb,
  output logic [31:0]      din,
  output logic             en,
  output logic [3:0]       we,
  output logic [1:0]       rdy,
  output logic [31:0]      size_data,
  output logic             bank,
  output logic             busy,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic [1:0]       fsm_state
);

  localparam int AW = $clog2(BANK_WORDS);  // word-address bits within a bank
  localparam int CW = AW + 1;              // counter must hold BANK_WORDS itself

  localparam logic [31:0]      BW32    = BANK_WORDS;
  localparam logic [CW-1:0]    FULL_N  = BW32[CW-1:0];
  localparam logic [CW-1:0]    CNT_ONE = 1;
  localparam logic [OVF_W-1:0] OVF_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sinc_q, sinc_d;
  logic             arm_q, arm_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    n_q, n_d;
  logic             bank_q, bank_d;
  logic [1:0]       rdy_q, rdy_d;
  logic [31:0]      size_q, size_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic          trig;
  logic          drop;
  logic          write;
  logic [CW-1:0] cnt_inc;
  logic [CW-1:0] n_eff;

  // arm_q stays low after reset until sinc has been seen high, so a sinc
  // already held low across reset release cannot fake a falling edge.
  assign trig    = ~sinc & sinc_q & arm_q;
  assign write   = (state_q == S_CAPT) && valid;
  assign cnt_inc = cnt_q + CNT_ONE;

  always_comb begin
    n_eff = n_samples[CW-1:0];
    if ((n_samples == 32'd0) || (n_samples > BW32)) begin
      n_eff = FULL_N;
    end
  end

  always_comb begin
    state_d = state_q;
    sinc_d  = sinc;
    arm_d   = arm_q | sinc;
    cnt_d   = cnt_q;
    n_d     = n_q;
    bank_d  = bank_q;
    rdy_d   = rdy_q & ~rdy_w;
    size_d  = size_q;
    drop    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig) begin
          if (rdy_q[bank_q]) begin
            drop = 1'b1;  // target bank still owned by the PS
          end else begin
            state_d = S_CAPT;
            n_d     = n_eff;
            cnt_d   = '0;
          end
        end
      end
      S_CAPT: begin
        drop = trig;
        if (valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == n_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        drop           = trig;
        rdy_d[bank_q]  = 1'b1;  // applied after the release mask: set wins
        size_d         = {{(32-CW){1'b0}}, n_q};
        bank_d         = ~bank_q;
        state_d        = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop && (ovf_q != {OVF_W{1'b1}})) begin
      ovf_d = ovf_q + OVF_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sinc_q  <= 1'b1;
      arm_q   <= 1'b0;
      cnt_q   <= '0;
      n_q     <= '0;
      bank_q  <= 1'b0;
      rdy_q   <= 2'b00;
      size_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      sinc_q  <= sinc_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      bank_q  <= bank_d;
      rdy_q   <= rdy_d;
      size_q  <= size_d;
      ovf_q   <= ovf_d;
    end
  end

  // Only the low AW counter bits reach the address, so a write can never
  // spill into the neighbouring bank.
  assign addr      = {{(29-AW){1'b0}}, bank_q, cnt_q[AW-1:0], 2'b00};
  assign clkb      = clk;
  assign din       = datos;
  assign en        = write;
  assign we        = {4{write}};
  assign rdy       = rdy_q;
  assign size_data = size_q;
  assign bank      = bank_q;
  assign busy      = (state_q == S_CAPT);
  assign ovf_cnt   = ovf_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Bench for bram_pingpong_ctrl, built with BANK_WORDS=16 and OVF_W=3 so
// full-bank and saturation cases stay short.
module tb_bram_pingpong_ctrl;

  localparam int BW = 16;
  localparam int OW = 3;

  logic          clk;
  logic          rst;
  logic          sinc;
  logic          valid;
  logic [31:0]   datos;
  logic [31:0]   n_samples;
  logic [1:0]    rdy_w;
  logic [31:0]   addr;
  logic          clkb;
  logic [31:0]   din;
  logic          en;
  logic [3:0]    we;
  logic [1:0]    rdy;
  logic [31:0]   size_data;
  logic          bank;
  logic          busy;
  logic [OW-1:0] ovf_cnt;
  logic [1:0]    fsm_state;

  int tests;
  int fails;

  bram_pingpong_ctrl #(.BANK_WORDS(BW), .OVF_W(OW)) dut (
    .clk(clk), .rst(rst), .sinc(sinc), .valid(valid), .datos(datos),
    .n_samples(n_samples), .rdy_w(rdy_w), .addr(addr), .clkb(clkb),
    .din(din), .en(en), .we(we), .rdy(rdy), .size_data(size_data),
    .bank(bank), .busy(busy), .ovf_cnt(ovf_cnt), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] n;
    int          vmode;       // 0: valid held high, 1: valid toggles 1,0
    int          retrig;      // capture cycle carrying an extra sinc pulse, -1 none
    logic [1:0]  rdy_w_pre;   // release pulse before the trigger
    logic [1:0]  rdy_w_done;  // release pulse in the cycle after the capture loop
    int          exp_words;
    logic [31:0] exp_base;
    logic [31:0] exp_last;
    logic [1:0]  exp_rdy;
    logic [31:0] exp_size;
    logic        exp_bank;
    logic [31:0] exp_ovf;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic [31:0] n, input int vm, input int rt,
                              input logic [1:0] pre, input logic [1:0] dn,
                              input int w, input logic [31:0] base,
                              input logic [31:0] last, input logic [1:0] r,
                              input logic [31:0] sz, input logic b,
                              input logic [31:0] ov);
    vec_t v;
    v.n = n; v.vmode = vm; v.retrig = rt; v.rdy_w_pre = pre; v.rdy_w_done = dn;
    v.exp_words = w; v.exp_base = base; v.exp_last = last; v.exp_rdy = r;
    v.exp_size = sz; v.exp_bank = b; v.exp_ovf = ov;
    return v;
  endfunction

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, addr, 32'h0);
    check({tag, "_en"}, {31'h0, en}, 32'h0);
    check({tag, "_we"}, {28'h0, we}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_rdy"}, {30'h0, rdy}, 32'h0);
    check({tag, "_bank"}, {31'h0, bank}, 32'h0);
    check({tag, "_size"}, size_data, 32'h0);
    check({tag, "_ovf"}, 32'(ovf_cnt), 32'h0);
    check({tag, "_state"}, {30'h0, fsm_state}, 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          nw;
    int          first_c;
    logic [31:0] last_a;
    logic        addr_ok;
    logic        done;
    n_samples = v.n;
    rdy_w     = v.rdy_w_pre;
    valid     = 1'b0;
    sinc      = 1'b1;
    tick();
    rdy_w = 2'b00;
    sinc  = 1'b0;
    tick();
    nw = 0; first_c = -1; last_a = 32'h0; addr_ok = 1'b1; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      sinc  = (c == v.retrig) ? 1'b0 : 1'b1;
      valid = (v.vmode == 0) ? 1'b1 : ((c % 2) == 0);
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
      if (addr !== v.exp_base + 32'(nw * 4)) addr_ok = 1'b0;
      if (en) begin
        if (we !== 4'hF) addr_ok = 1'b0;
        if (first_c < 0) first_c = c;
        last_a = addr;
        nw++;
      end else if (we !== 4'h0) begin
        addr_ok = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_finished"}, {31'h0, done}, 32'h1);
    rdy_w = v.rdy_w_done;
    valid = 1'b0;
    sinc  = 1'b1;
    tick();
    rdy_w = 2'b00;
    check({tag, "_words"}, 32'(nw), 32'(v.exp_words));
    check({tag, "_addr_seq"}, {31'h0, addr_ok}, 32'h1);
    if (v.exp_words > 0) check({tag, "_last_addr"}, last_a, v.exp_last);
    if (v.exp_words > 0 && v.vmode == 0) check({tag, "_latency"}, 32'(first_c), 32'h0);
    check({tag, "_rdy"}, {30'h0, rdy}, {30'h0, v.exp_rdy});
    check({tag, "_size"}, size_data, v.exp_size);
    check({tag, "_bank"}, {31'h0, bank}, {31'h0, v.exp_bank});
    check({tag, "_ovf"}, 32'(ovf_cnt), v.exp_ovf);
  endtask

  initial begin
    int   nw;
    vec_t v;
    tests = 0;
    fails = 0;
    rst = 1'b1; sinc = 1'b1; valid = 1'b0; datos = 32'h0;
    n_samples = 32'd0; rdy_w = 2'b00;

    //            n    vm  rt  pre    done   w   base   last   rdy    size bank ovf
    tbl[0]  = mk(8,    0, -1, 2'b00, 2'b00, 8,  'h00, 'h1C, 2'b01, 8,  1, 0);
    tbl[1]  = mk(4,    1, -1, 2'b00, 2'b00, 4,  'h40, 'h4C, 2'b11, 4,  0, 0);
    tbl[2]  = mk(5,    0, -1, 2'b00, 2'b00, 0,  'h00, 'h00, 2'b11, 4,  0, 1);
    tbl[3]  = mk(3,    0, -1, 2'b01, 2'b00, 3,  'h00, 'h08, 2'b11, 3,  1, 1);
    tbl[4]  = mk(0,    0, -1, 2'b11, 2'b00, 16, 'h40, 'h7C, 2'b10, 16, 0, 1);
    tbl[5]  = mk(BW+5, 0, -1, 2'b10, 2'b00, 16, 'h00, 'h3C, 2'b01, 16, 1, 1);
    tbl[6]  = mk(16,   0, -1, 2'b00, 2'b00, 16, 'h40, 'h7C, 2'b11, 16, 0, 1);
    tbl[7]  = mk(6,    0,  2, 2'b11, 2'b00, 6,  'h00, 'h14, 2'b01, 6,  1, 2);
    tbl[8]  = mk(2,    0, -1, 2'b00, 2'b10, 2,  'h40, 'h44, 2'b11, 2,  0, 2);
    tbl[9]  = mk(7,    1, -1, 2'b00, 2'b01, 0,  'h00, 'h00, 2'b10, 2,  0, 3);
    tbl[10] = mk(7,    1, -1, 2'b00, 2'b00, 7,  'h00, 'h18, 2'b11, 7,  1, 3);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    tick();
    datos = 32'hA5C3_0F96;
    rdy_w = 2'b11;   // release of empty banks must not change anything
    tick();
    rdy_w = 2'b00;
    @(negedge clk);
    check("din_passthrough", din, 32'hA5C3_0F96);
    check("clkb_follows_clk", {31'h0, clkb}, {31'h0, clk});
    check("rdy_w_on_empty", {30'h0, rdy}, 32'h0);
    tick();

    for (int i = 0; i < 11; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // overflow counter saturates at all-ones with both banks full
    for (int i = 0; i < 5; i++) begin
      v = mk(1, 0, -1, 2'b00, 2'b00, 0, 'h0, 'h0, 2'b11, 7, 1,
             ((4 + i) > 7) ? 32'd7 : 32'(4 + i));
      run_vec(v, $sformatf("sat%0d", i));
    end

    // release both banks, then check a repeated release is harmless
    rdy_w = 2'b11;
    tick();
    rdy_w = 2'b11;
    tick();
    rdy_w = 2'b00;
    check("release_both", {30'h0, rdy}, 32'h0);

    // reset in the middle of a capture, with sinc held low across release
    n_samples = 32'd8;
    valid = 1'b1;
    sinc = 1'b0;
    tick();
    sinc = 1'b1;
    nw = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (en) nw++;
      @(posedge clk);
      #1;
    end
    check("pre_reset_writes", 32'(nw), 32'd3);
    rst  = 1'b1;
    sinc = 1'b0;
    #2;
    check_reset_values("midrst");
    tick();
    rst = 1'b0;
    nw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || en) nw++;
      @(posedge clk);
      #1;
    end
    check("no_trigger_after_release", 32'(nw), 32'd0);
    valid = 1'b0;
    v = mk(8, 0, -1, 2'b00, 2'b00, 8, 'h00, 'h1C, 2'b01, 8, 1, 0);
    run_vec(v, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
